// File: rtl/memory_decoder_pkg.sv
// Shared types and helpers for the burst address decoder: FSM state,
// bounded one-hot decode and next-address stepping.
package memory_decoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

  // Upper bound on DEPTH; callers truncate the result to their own DEPTH.
  localparam int unsigned MAX_LINES = 256;

  function automatic logic [MAX_LINES-1:0] onehot(input logic [31:0] addr,
                                                  input int unsigned depth);
    logic [MAX_LINES-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_LINES; i++) begin
      r[i] = (i == addr) && (i < depth);
    end
    return r;
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] cur,
                                            input logic        wrap,
                                            input int unsigned depth,
                                            input int unsigned addr_w);
    logic [31:0] mask;
    mask = (addr_w >= 32) ? '1 : ((32'd1 << addr_w) - 32'd1);
    if (wrap && (cur == depth - 1)) begin
      return '0;
    end
    return (cur + 32'd1) & mask;
  endfunction

endpackage

// File: rtl/onehot_line_decoder.sv
// Combinational binary-to-one-hot line decode; addresses at or beyond
// DEPTH produce no select and raise err_o.
module onehot_line_decoder
  import memory_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DEPTH-1:0]  sel_o,
  output logic              err_o
);

  always_comb begin
    sel_o = DEPTH'(onehot(32'(addr_i), DEPTH));
    err_o = (32'(addr_i) >= DEPTH);
  end

endmodule

// File: rtl/burst_address_decoder.sv
// Handshaked burst decoder: accepts start address + length, then emits one
// registered one-hot line select per beat with last/out-of-range flags.
module burst_address_decoder
  import memory_decoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LEN_W  = 3,
  parameter int unsigned WRAP   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [LEN_W-1:0]  in_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DEPTH-1:0]  out_address,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_err,
  output logic              busy
);

  state_e              state_q;
  logic [ADDR_W-1:0]   cur_q;
  logic [LEN_W-1:0]    rem_q;
  logic [DEPTH-1:0]    sel_q;
  logic                valid_q;
  logic                last_q;
  logic                err_q;

  logic [ADDR_W-1:0]   step_addr;
  logic [ADDR_W-1:0]   cur_d;
  logic [DEPTH-1:0]    dec_sel;
  logic                dec_err;

  // One decoder serves both the burst start (IDLE) and the advance (ISSUE).
  always_comb begin
    step_addr = ADDR_W'(next_addr(32'(cur_q), WRAP != 0, DEPTH, ADDR_W));
    cur_d     = (state_q == IDLE) ? in_address : step_addr;
  end

  onehot_line_decoder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_dec (
    .addr_i (cur_d),
    .sel_o  (dec_sel),
    .err_o  (dec_err)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_q <= ISSUE;
            cur_q   <= cur_d;
            rem_q   <= in_len;
            sel_q   <= dec_sel;
            err_q   <= dec_err;
            last_q  <= (in_len == '0);
            valid_q <= 1'b1;
          end
        end
        ISSUE: begin
          if (out_ready) begin
            if (rem_q == '0) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              err_q   <= 1'b0;
            end else begin
              rem_q  <= rem_q - LEN_W'(1);
              cur_q  <= cur_d;
              sel_q  <= dec_sel;
              err_q  <= dec_err;
              last_q <= (rem_q == LEN_W'(1));
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = reset_n && (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign out_valid   = valid_q;
  assign out_address = sel_q;
  assign out_index   = cur_q;
  assign out_last    = last_q;
  assign out_err     = err_q;

endmodule

// File: tb/tb_burst_address_decoder.sv
// Directed bench for burst_address_decoder: default, out-of-range
// (ADDR_W=3, DEPTH=5, WRAP=0) and single-line (DEPTH=1) configurations.
module tb_burst_address_decoder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // DUT A: defaults
  logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [1:0] a_in_address, a_out_index;
  logic [2:0] a_in_len;
  logic [3:0] a_out_address;
  logic       a_out_last, a_out_err, a_busy;

  // DUT B: out-of-range capable
  logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0] b_in_address, b_out_index;
  logic [2:0] b_in_len;
  logic [4:0] b_out_address;
  logic       b_out_last, b_out_err, b_busy;

  // DUT C: single select line
  logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [1:0] c_in_address, c_out_index;
  logic [2:0] c_in_len;
  logic [0:0] c_out_address;
  logic       c_out_last, c_out_err, c_busy;

  burst_address_decoder u_dut_a (
    .clk(clk), .reset_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_address(a_in_address), .in_len(a_in_len),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_address(a_out_address), .out_index(a_out_index),
    .out_last(a_out_last), .out_err(a_out_err), .busy(a_busy)
  );

  burst_address_decoder #(.ADDR_W(3), .DEPTH(5), .LEN_W(3), .WRAP(0)) u_dut_b (
    .clk(clk), .reset_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_address(b_in_address), .in_len(b_in_len),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_address(b_out_address), .out_index(b_out_index),
    .out_last(b_out_last), .out_err(b_out_err), .busy(b_busy)
  );

  burst_address_decoder #(.ADDR_W(2), .DEPTH(1), .LEN_W(3), .WRAP(1)) u_dut_c (
    .clk(clk), .reset_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_address(c_in_address), .in_len(c_in_len),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_address(c_out_address), .out_index(c_out_index),
    .out_last(c_out_last), .out_err(c_out_err), .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Beat checks sample at the negedge, then step one cycle.
  task automatic beat_a(input string tag, input logic [3:0] sel, input logic [1:0] idx,
                        input logic last, input logic err);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'd1);
    chk({tag, ".sel"},   32'(a_out_address), 32'(sel));
    chk({tag, ".idx"},   32'(a_out_index), 32'(idx));
    chk({tag, ".last"},  32'(a_out_last), 32'(last));
    chk({tag, ".err"},   32'(a_out_err), 32'(err));
    chk({tag, ".rdy"},   32'(a_in_ready), 32'd0);
    @(negedge clk);
  endtask

  task automatic beat_b(input string tag, input logic [4:0] sel, input logic [2:0] idx,
                        input logic last, input logic err);
    chk({tag, ".valid"}, 32'(b_out_valid), 32'd1);
    chk({tag, ".sel"},   32'(b_out_address), 32'(sel));
    chk({tag, ".idx"},   32'(b_out_index), 32'(idx));
    chk({tag, ".last"},  32'(b_out_last), 32'(last));
    chk({tag, ".err"},   32'(b_out_err), 32'(err));
    @(negedge clk);
  endtask

  task automatic beat_c(input string tag, input logic [1:0] idx, input logic last);
    chk({tag, ".valid"}, 32'(c_out_valid), 32'd1);
    chk({tag, ".sel"},   32'(c_out_address), 32'd1);
    chk({tag, ".idx"},   32'(c_out_index), 32'(idx));
    chk({tag, ".last"},  32'(c_out_last), 32'(last));
    chk({tag, ".err"},   32'(c_out_err), 32'd0);
    @(negedge clk);
  endtask

  task automatic idle_a(input string tag);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'd0);
    chk({tag, ".rdy"},   32'(a_in_ready), 32'd1);
    chk({tag, ".busy"},  32'(a_busy), 32'd0);
    chk({tag, ".last"},  32'(a_out_last), 32'd0);
    chk({tag, ".err"},   32'(a_out_err), 32'd0);
  endtask

  task automatic idle_b(input string tag);
    chk({tag, ".valid"}, 32'(b_out_valid), 32'd0);
    chk({tag, ".rdy"},   32'(b_in_ready), 32'd1);
    chk({tag, ".err"},   32'(b_out_err), 32'd0);
  endtask

  task automatic req_a(input logic [1:0] addr, input logic [2:0] len);
    a_in_valid = 1'b1; a_in_address = addr; a_in_len = len;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic req_b(input logic [2:0] addr, input logic [2:0] len);
    b_in_valid = 1'b1; b_in_address = addr; b_in_len = len;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic req_c(input logic [1:0] addr, input logic [2:0] len);
    c_in_valid = 1'b1; c_in_address = addr; c_in_len = len;
    @(negedge clk);
    c_in_valid = 1'b0;
  endtask

  task automatic reset_a(input string tag);
    chk({tag, ".valid"}, 32'(a_out_valid), 32'd0);
    chk({tag, ".sel"},   32'(a_out_address), 32'd0);
    chk({tag, ".idx"},   32'(a_out_index), 32'd0);
    chk({tag, ".last"},  32'(a_out_last), 32'd0);
    chk({tag, ".err"},   32'(a_out_err), 32'd0);
    chk({tag, ".busy"},  32'(a_busy), 32'd0);
    chk({tag, ".rdy"},   32'(a_in_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] eidx;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_address = '0; a_in_len = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_address = '0; b_in_len = '0; b_out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_address = '0; c_in_len = '0; c_out_ready = 1'b1;
    repeat (2) @(negedge clk);

    reset_a("reset");
    chk("reset.b_rdy", 32'(b_in_ready), 32'd0);
    chk("reset.b_sel", 32'(b_out_address), 32'd0);
    chk("reset.c_valid", 32'(c_out_valid), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    idle_a("post_reset");

    // Single beat
    req_a(2'd2, 3'd0);
    beat_a("single", 4'b0100, 2'd2, 1'b1, 1'b0);
    idle_a("single.after");

    // Wrap inside burst
    req_a(2'd3, 3'd2);
    beat_a("wrap0", 4'b1000, 2'd3, 1'b0, 1'b0);
    beat_a("wrap1", 4'b0001, 2'd0, 1'b0, 1'b0);
    beat_a("wrap2", 4'b0010, 2'd1, 1'b1, 1'b0);
    idle_a("wrap.after");

    // Maximum length: 8 beats from address 1
    req_a(2'd1, 3'd7);
    for (int i = 0; i < 8; i++) begin
      eidx = 2'(1 + i);
      beat_a("maxlen", 4'b0001 << eidx, eidx, (i == 7), 1'b0);
    end
    idle_a("maxlen.after");

    // Backpressure with ignored in_valid pulses
    req_a(2'd0, 3'd3);
    beat_a("bp0", 4'b0001, 2'd0, 1'b0, 1'b0);
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_address = 2'd3; a_in_len = 3'd0;
    for (int i = 0; i < 3; i++) begin
      chk("stall.valid", 32'(a_out_valid), 32'd1);
      chk("stall.sel",   32'(a_out_address), 32'b0010);
      chk("stall.idx",   32'(a_out_index), 32'd1);
      chk("stall.last",  32'(a_out_last), 32'd0);
      chk("stall.rdy",   32'(a_in_ready), 32'd0);
      @(negedge clk);
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    beat_a("bp1", 4'b0010, 2'd1, 1'b0, 1'b0);
    beat_a("bp2", 4'b0100, 2'd2, 1'b0, 1'b0);
    beat_a("bp3", 4'b1000, 2'd3, 1'b1, 1'b0);
    idle_a("bp.after");

    // Reset mid-burst
    req_a(2'd0, 3'd5);
    beat_a("rst0", 4'b0001, 2'd0, 1'b0, 1'b0);
    beat_a("rst1", 4'b0010, 2'd1, 1'b0, 1'b0);
    chk("rst2.sel", 32'(a_out_address), 32'b0100);
    rst_n = 1'b0;
    @(negedge clk);
    reset_a("midreset");
    rst_n = 1'b1;
    req_a(2'd1, 3'd0);
    beat_a("rst.new", 4'b0010, 2'd1, 1'b1, 1'b0);
    idle_a("rst.after");

    // Out-of-range beats, no wrap
    req_b(3'd3, 3'd3);
    beat_b("oor0", 5'b01000, 3'd3, 1'b0, 1'b0);
    beat_b("oor1", 5'b10000, 3'd4, 1'b0, 1'b0);
    beat_b("oor2", 5'b00000, 3'd5, 1'b0, 1'b1);
    beat_b("oor3", 5'b00000, 3'd6, 1'b1, 1'b1);
    idle_b("oor.after");

    // Out-of-range start, modulo 2**ADDR_W rollover
    req_b(3'd6, 3'd2);
    beat_b("roll0", 5'b00000, 3'd6, 1'b0, 1'b1);
    beat_b("roll1", 5'b00000, 3'd7, 1'b0, 1'b1);
    beat_b("roll2", 5'b00001, 3'd0, 1'b1, 1'b0);
    idle_b("roll.after");

    // DEPTH=1: every beat selects line 0
    req_c(2'd0, 3'd2);
    beat_c("d1_0", 2'd0, 1'b0);
    beat_c("d1_1", 2'd0, 1'b0);
    beat_c("d1_2", 2'd0, 1'b1);
    chk("d1.after.valid", 32'(c_out_valid), 32'd0);
    chk("d1.after.rdy",   32'(c_in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
